factorial_engine: RTL
=====================

# factorial_engine

Self-contained, parametrised factorial unit: accepts an operand `n` with a start pulse, iterates multiply / decrement / test internally, and returns `n!` truncated to `WIDTH` bits with a sticky overflow flag. It replaces the fixed 2-bit controller plus external datapath arrangement. Control and datapath are merged, with a multi-cycle shift-add multiplier and a start/busy/done handshake, so higher-level logic can issue requests without sequencing select lines.

## Interface
- `WIDTH`, default 16: result and accumulator width; must be at least 2.
- `N_WIDTH`, default 5: operand width; also the number of multiply cycles per iteration.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: reset; asynchronous, active-high.
- `start`, input, 1: request; sampled only in IDLE.
- `n`, input, `N_WIDTH`: operand; latched on the accepting edge.
- `busy`, output, 1: high while a computation is in progress.
- `done`, output, 1: one-cycle completion pulse.
- `result`, output, `WIDTH`: `n! mod 2^WIDTH`; held until the next completion.
- `overflow`, output, 1: high iff the true `n!` is at least `2^WIDTH`; held with `result`.

## Operation
- States: IDLE, CHECK, MUL, SUB.
- Internal registers:
  - `cnt`: `N_WIDTH` bits.
  - `acc`: `WIDTH` bits.
  - `prod`, `mcand`: `WIDTH+N_WIDTH` bits each.
  - `mplr`: `N_WIDTH` bits.
  - `bitcnt`.
  - `ovf`: sticky.
- IDLE:
  - `busy` is 0.
  - On `start=1`: set `cnt<=n`, `acc<=1`, `ovf<=0`, and go to CHECK.
- CHECK:
  - If `cnt<=1`: set `result<=acc`, `overflow<=ovf`, `done<=1`, and go to IDLE.
  - Otherwise: load `prod<=0`, `mcand<=acc` (zero-extended), `mplr<=cnt`, `bitcnt<=0`, and go to MUL.
- MUL, every cycle:
  - If `mplr[0]`: `prod+=mcand`.
  - Then `mcand<<=1`, `mplr>>=1`, `bitcnt++`.
  - On the cycle where `bitcnt==N_WIDTH-1`, using the updated product value:
    - `acc<=prod_next[WIDTH-1:0]`.
    - `ovf<=ovf | (|prod_next[WIDTH+N_WIDTH-1:WIDTH])`.
    - Go to SUB.
- SUB: `cnt<=cnt-1`, then go to CHECK.
- Arithmetic rules:
  - Truncation at each step preserves `n! mod 2^WIDTH`.
  - `ovf` is sticky, so once set it stays set for the rest of the computation.
  - `cnt` never underflows, because SUB is only entered with `cnt>=2`.
- `start` is ignored while `busy=1`. There is no queueing.
- `n=0` and `n=1` both produce `result=1`, `overflow=0`.

## Timing
- Reset values, all asserted asynchronously:
  - State: IDLE.
  - `busy=0`, `done=0`, `result=0`, `overflow=0`.
  - `cnt`, `acc`, `prod`, `mcand`, `mplr`, `bitcnt`, `ovf` all 0.
- `busy` and `done` are registered.
  - `busy` rises on the accepting edge and falls on the completion edge.
  - `busy` and `done` are never high together.
- `done` is high for exactly the one cycle after the completion edge. `result` and `overflow` change only on that edge.
- Latency is counted from the accepting edge to the completion edge:
  - `n<=1`: 1 cycle.
  - Otherwise: `1 + (n-1)*(N_WIDTH+2)` cycles.
- A `start` in the cycle where `done=1` is accepted (state is IDLE), which allows back-to-back operation. `result` stays valid until the next completion.
- Reset mid-operation aborts immediately:
  - All outputs return to their reset values.
  - No `done` pulse is produced.
  - The first `start` after reset deasserts is accepted normally.
- `n` is sampled only on the accepting edge. Later changes to `n` have no effect on the computation in progress.

## Test plan
- Defaults, `n=0`, then `n=1`: each gives `done` 1 cycle after accept, `result=1`, `overflow=0`, `busy` high for exactly 1 cycle.
- `n=5`: gives `result=120`, `overflow=0`, `done` exactly 29 cycles after the accepting edge, one-cycle `done` pulse.
- `n=8`, then `n=9`:
  - `n=8` gives `result=40320`, `overflow=0`.
  - `n=9` gives `result=35200`, `overflow=1`.
  - `overflow` clears on the next run with `n=3` (`result=6`).
- `start` pulsed mid-computation with a different `n`: ignored; the original result is delivered with the original latency. A `start` in the `done` cycle launches the next run with no idle gap.
- Assert `rst` during MUL of an `n=6` run:
  - All outputs go to 0 asynchronously and no `done` pulse appears.
  - After release, `n=4` gives `result=24` at latency 22.
- `WIDTH=8`, `N_WIDTH=3`, `n=7`: `result=5040 mod 256 = 176`, `overflow=1`, latency 31.

Source files
------------

// File: rtl/factorial_engine.sv
// rtl/factorial_engine.sv - iterative factorial unit with shift-add multiplier
//
// Computes n! mod 2^WIDTH with a sticky overflow flag using a
// start/busy/done handshake. Each iteration runs CHECK, then N_WIDTH
// shift-add MUL cycles, then SUB.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous active-high reset
//   start    - request, sampled only in IDLE
//   n        - operand, latched on the accepting edge
//   busy     - high while a computation is in progress
//   done     - one-cycle completion pulse
//   result   - n! mod 2^WIDTH, held until the next completion
//   overflow - true n! >= 2^WIDTH, held with result
module factorial_engine #(
  parameter int WIDTH   = 16,
  parameter int N_WIDTH = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  localparam int PW = WIDTH + N_WIDTH;
  localparam int BW = $clog2(N_WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    MUL   = 2'd2,
    SUB   = 2'd3
  } state_t;

  state_t             state;
  logic [N_WIDTH-1:0] cnt;
  logic [WIDTH-1:0]   acc;
  logic [PW-1:0]      prod;
  logic [PW-1:0]      mcand;
  logic [N_WIDTH-1:0] mplr;
  logic [BW-1:0]      bitcnt;
  logic               ovf;
  logic [PW-1:0]      prod_next;

  // Partial product after this cycle's conditional add; the last MUL cycle
  // commits this value directly rather than waiting another cycle.
  always_comb begin
    prod_next = prod;
    if (mplr[0]) begin
      prod_next = prod + mcand;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      overflow <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      prod     <= '0;
      mcand    <= '0;
      mplr     <= '0;
      bitcnt   <= '0;
      ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= n;
            acc   <= {{(WIDTH-1){1'b0}}, 1'b1};
            ovf   <= 1'b0;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end

        CHECK: begin
          if (cnt <= N_WIDTH'(1)) begin
            result   <= acc;
            overflow <= ovf;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            prod   <= '0;
            mcand  <= {{N_WIDTH{1'b0}}, acc};
            mplr   <= cnt;
            bitcnt <= '0;
            state  <= MUL;
          end
        end

        MUL: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplr   <= mplr >> 1;
          bitcnt <= bitcnt + BW'(1);
          if (bitcnt == BW'(N_WIDTH - 1)) begin
            acc   <= prod_next[WIDTH-1:0];
            // Any bit above WIDTH means the true product left the window.
            ovf   <= ovf | (|prod_next[PW-1:WIDTH]);
            state <= SUB;
          end
        end

        SUB: begin
          // Only reached with cnt >= 2, so this never wraps.
          cnt   <= cnt - N_WIDTH'(1);
          state <= CHECK;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
